// File: rtl/imem_loadable_if.sv
// Fetch port and byte-stream loader port of the loadable instruction memory.
// master = CPU fetch stage plus byte source; slave = the memory.
interface imem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 16
);
  logic              fetch_en;
  logic [PC_W-1:0]   fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              busy;
  logic [ADDR_W:0]   prog_len;
  logic              ld_err;

  modport master (
    output fetch_en, fetch_addr, ld_start, ld_valid, ld_byte,
    input  fetch_data, fetch_valid, ld_ready, busy, prog_len, ld_err
  );

  modport slave (
    input  fetch_en, fetch_addr, ld_start, ld_valid, ld_byte,
    output fetch_data, fetch_valid, ld_ready, busy, prog_len, ld_err
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction RAM: 1-cycle registered fetch, NOP past prog_len; fetch stalls while busy.
// Loader takes a 16-bit word count then MSB-first words; ld_ready gates bytes, gaps in ld_valid allowed.
module imem_loadable #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  imem_loadable_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     DEPTH_N = 16'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_WORD, S_FINISH} state_t;

  state_t            state_q;
  logic              busy_q, ld_ready_q, ld_err_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       n_q, wcnt_q;
  logic [ADDR_W:0]   widx_q;
  logic [BC_W-1:0]   bcnt_q;
  logic [DATA_W-9:0] wbuf_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              byte_acc, last_byte, mem_we, fetch_acc, fetch_hit;
  logic [15:0]       n_d;
  logic [DATA_W-1:0] word_d, fetch_data_d;

  assign byte_acc  = bus.ld_valid & ld_ready_q;
  assign last_byte = (bcnt_q == BC_W'(BYTES - 1));
  assign n_d       = {cnt_hi_q, bus.ld_byte};
  assign word_d    = {wbuf_q, bus.ld_byte};
  // widx_q saturates at DEPTH, so its top bit alone marks words to discard
  assign mem_we    = (state_q == S_WORD) & byte_acc & last_byte & ~widx_q[ADDR_W] & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_err_q   <= 1'b0;
      prog_len_q <= '0;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      widx_q     <= '0;
      bcnt_q     <= '0;
      wbuf_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ld_start) begin
            state_q    <= S_CNT_HI;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b1;
            prog_len_q <= '0;
            ld_err_q   <= 1'b0;
          end
        end
        S_CNT_HI: begin
          if (byte_acc) begin
            cnt_hi_q <= bus.ld_byte;
            state_q  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (byte_acc) begin
            n_q    <= n_d;
            wcnt_q <= '0;
            widx_q <= '0;
            bcnt_q <= '0;
            if (n_d > DEPTH_N) ld_err_q <= 1'b1;
            if (n_d == 16'd0) begin
              state_q    <= S_FINISH;
              ld_ready_q <= 1'b0;
            end else begin
              state_q <= S_WORD;
            end
          end
        end
        S_WORD: begin
          if (byte_acc) begin
            wbuf_q <= word_d[DATA_W-9:0];
            if (last_byte) begin
              bcnt_q <= '0;
              wcnt_q <= wcnt_q + 16'd1;
              if (!widx_q[ADDR_W]) widx_q <= widx_q + (ADDR_W + 1)'(1);
              if (wcnt_q + 16'd1 == n_q) begin
                state_q    <= S_FINISH;
                ld_ready_q <= 1'b0;
              end
            end else begin
              bcnt_q <= bcnt_q + BC_W'(1);
            end
          end
        end
        S_FINISH: begin
          prog_len_q <= (n_q > DEPTH_N) ? DEPTH_W : n_q[ADDR_W:0];
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Contents survive reset; prog_len gating keeps stale words unreachable.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[widx_q[ADDR_W-1:0]] <= word_d;
  end

  assign fetch_acc    = bus.fetch_en & ~busy_q;
  assign fetch_hit    = (bus.fetch_addr < PC_W'(prog_len_q));
  assign fetch_data_d = fetch_hit ? mem[bus.fetch_addr[ADDR_W-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) fetch_data_q <= fetch_data_d;
    end
  end

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.busy        = busy_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.ld_err      = ld_err_q;
endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench: one default-size memory and one 4-word memory driven by the same stimulus.
module tb_imem_loadable;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fetch_en;
  logic [15:0] fetch_addr;
  logic        ld_start, ld_valid;
  logic [7:0]  ld_byte;

  int checks   = 0;
  int failures = 0;
  int acc_a    = 0;
  int busy_cyc = 0;
  int a0, b0;

  imem_loadable_if #(.DATA_W(16), .ADDR_W(8), .PC_W(16)) bus_a ();
  imem_loadable_if #(.DATA_W(16), .ADDR_W(2), .PC_W(16)) bus_b ();

  assign bus_a.fetch_en   = fetch_en;
  assign bus_a.fetch_addr = fetch_addr;
  assign bus_a.ld_start   = ld_start;
  assign bus_a.ld_valid   = ld_valid;
  assign bus_a.ld_byte    = ld_byte;
  assign bus_b.fetch_en   = fetch_en;
  assign bus_b.fetch_addr = fetch_addr;
  assign bus_b.ld_start   = ld_start;
  assign bus_b.ld_valid   = ld_valid;
  assign bus_b.ld_byte    = ld_byte;

  imem_loadable #(.DATA_W(16), .ADDR_W(8), .PC_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );
  imem_loadable #(.DATA_W(16), .ADDR_W(2), .PC_W(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  always @(posedge clk) begin
    if (bus_a.ld_valid && bus_a.ld_ready) acc_a <= acc_a + 1;
    if (bus_a.busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      ld_valid = 1'b0;
      step();
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    n = 0;
    while (!bus_a.ld_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("ld_ready_timeout", 32'd0, 32'd1);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic finish_load(input string tag);
    chk({tag, "_busy_fin"}, bus_a.busy, 1);
    step();
    chk({tag, "_busy_done"}, bus_a.busy, 0);
  endtask

  task automatic fetch_chk(input string tag, input bit use_b, input logic [15:0] addr,
                           input logic [15:0] exp);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    step();
    fetch_en = 1'b0;
    chk({tag, "_vld"}, use_b ? bus_b.fetch_valid : bus_a.fetch_valid, 1);
    chk(tag, use_b ? bus_b.fetch_data : bus_a.fetch_data, exp);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    step(); step();
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_ld_ready", bus_a.ld_ready, 0);
    chk("rst_prog_len", bus_a.prog_len, 0);
    chk("rst_ld_err", bus_a.ld_err, 0);
    chk("rst_fetch_valid", bus_a.fetch_valid, 0);
    chk("rst_fetch_data", bus_a.fetch_data, 0);
    rst = 1'b0;
    step();
    fetch_chk("empty_f0", 0, 16'd0, 16'h0000);

    // basic load, back-to-back bytes
    a0 = acc_a;
    start_load();
    chk("basic_busy_rise", bus_a.busy, 1);
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_word(16'hA000, 0); send_word(16'h0000, 0); send_word(16'hC66B, 0);
    finish_load("basic");
    chk("basic_prog_len", bus_a.prog_len, 3);
    chk("basic_ld_err", bus_a.ld_err, 0);
    chk("basic_bytes", acc_a - a0, 8);
    fetch_chk("basic_f0", 0, 16'd0, 16'hA000);
    fetch_chk("basic_f1", 0, 16'd1, 16'h0000);
    fetch_chk("basic_f2", 0, 16'd2, 16'hC66B);
    fetch_chk("basic_f3", 0, 16'd3, 16'h0000);
    fetch_en = 1'b1; fetch_addr = 16'd0;
    step();
    chk("b2b_d0", bus_a.fetch_data, 16'hA000);
    fetch_addr = 16'd2;
    step();
    chk("b2b_v1", bus_a.fetch_valid, 1);
    chk("b2b_d1", bus_a.fetch_data, 16'hC66B);
    fetch_en = 1'b0;
    step();
    chk("b2b_idle_vld", bus_a.fetch_valid, 0);

    // back-pressure: 3 idle cycles before every byte
    a0 = acc_a;
    start_load();
    chk("bp_pl_clear", bus_a.prog_len, 0);
    send_byte(8'h00, 3); send_byte(8'h03, 3);
    send_word(16'hA000, 3); send_word(16'h0000, 3); send_word(16'hC66B, 3);
    finish_load("bp");
    chk("bp_prog_len", bus_a.prog_len, 3);
    chk("bp_bytes", acc_a - a0, 8);
    fetch_chk("bp_f0", 0, 16'd0, 16'hA000);
    fetch_chk("bp_f1", 0, 16'd1, 16'h0000);
    fetch_chk("bp_f2", 0, 16'd2, 16'hC66B);

    // fetch while busy and ignored restart
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    fetch_en = 1'b1; fetch_addr = 16'd0; ld_start = 1'b1;
    step();
    fetch_en = 1'b0; ld_start = 1'b0;
    chk("busy_fetch_vld", bus_a.fetch_valid, 0);
    chk("busy_fetch_hold", bus_a.fetch_data, 16'hC66B);
    chk("busy_still", bus_a.busy, 1);
    send_word(16'h1234, 0); send_word(16'h5678, 0);
    finish_load("restart");
    chk("restart_prog_len", bus_a.prog_len, 2);
    fetch_chk("restart_f0", 0, 16'd0, 16'h1234);
    fetch_chk("restart_f1", 0, 16'd1, 16'h5678);
    fetch_chk("restart_f2", 0, 16'd2, 16'h0000);

    // stray bytes in IDLE, then zero-length load
    a0 = acc_a;
    ld_valid = 1'b1; ld_byte = 8'hFF;
    step(); step();
    ld_valid = 1'b0;
    chk("idle_drop", acc_a - a0, 0);
    chk("idle_busy", bus_a.busy, 0);
    b0 = busy_cyc;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    step(); step();
    chk("zero_busy_cycles", busy_cyc - b0, 3);
    chk("zero_prog_len", bus_a.prog_len, 0);
    fetch_chk("zero_f0", 0, 16'd0, 16'h0000);
    fetch_chk("zero_f1", 0, 16'd1, 16'h0000);

    // oversize load into the 4-word memory
    a0 = acc_a;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h06, 0);
    for (int w = 1; w <= 6; w++) send_word(16'(w), 0);
    finish_load("over");
    chk("over_bytes", acc_a - a0, 14);
    chk("over_b_err", bus_b.ld_err, 1);
    chk("over_b_prog_len", bus_b.prog_len, 4);
    chk("over_a_err", bus_a.ld_err, 0);
    chk("over_a_prog_len", bus_a.prog_len, 6);
    fetch_chk("over_f0", 1, 16'd0, 16'h0001);
    fetch_chk("over_f1", 1, 16'd1, 16'h0002);
    fetch_chk("over_f2", 1, 16'd2, 16'h0003);
    fetch_chk("over_f3", 1, 16'd3, 16'h0004);
    fetch_chk("over_f4", 1, 16'd4, 16'h0000);

    // reset mid-load, then a fresh single-word load
    start_load();
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_word(16'h0011, 0); send_word(16'h0022, 0); send_word(16'h0033, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", bus_a.busy, 0);
    chk("mrst_prog_len", bus_a.prog_len, 0);
    chk("mrst_ld_ready", bus_a.ld_ready, 0);
    chk("mrst_fetch_valid", bus_a.fetch_valid, 0);
    fetch_chk("mrst_f0", 0, 16'd0, 16'h0000);
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(16'hABCD, 0);
    finish_load("fresh");
    chk("fresh_prog_len", bus_a.prog_len, 1);
    chk("fresh_b_err", bus_b.ld_err, 0);
    fetch_chk("fresh_f0", 0, 16'd0, 16'hABCD);
    fetch_chk("fresh_f1", 0, 16'd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
